two_4_input_and_tester: RTL and testbench

//  Stimulus/response end of the dual 4-input AND gate interface: drives a1..d2 into
//  a gate under test and checks y1,y2 against the expected AND of each input group.

---
 rtl/two_4_input_and_tester_pkg.sv | 21 ++
 rtl/two_4_input_and_tester_sync_2ff.sv | 25 ++
 rtl/two_4_input_and_tester.sv | 155 +++++++++++++++
 tb/tb_two_4_input_and_tester.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/two_4_input_and_tester_pkg.sv
// Shared types and constants for the dual 4-input AND gate tester.
package two_4_input_and_tester_pkg;

  localparam int VEC_W = 8;
  localparam int ERR_W = 9;

  localparam logic [VEC_W-1:0] LAST_VEC = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Expected gate response {y1, y2} for a stimulus vector {a1..d1, a2..d2}.
  function automatic logic [1:0] expected_y(input logic [VEC_W-1:0] vec);
    return {&vec[7:4], &vec[3:0]};
  endfunction

endpackage

// File: rtl/two_4_input_and_tester_sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit, cleared by the tester reset.
module two_4_input_and_tester_sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous input through two flops before anything uses it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/two_4_input_and_tester.sv
// Exhaustive sweep tester for a dual 4-input AND gate: drives all 256 vectors,
// lets each settle, compares synchronised gate outputs against the expected AND,
// counts failing vectors and remembers the first one.
//
// Handshake: start is a level, sampled only in IDLE or DONE; while busy it is
// ignored. done is a one-state flag that stays high until start is seen again.
module two_4_input_and_tester
  import two_4_input_and_tester_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             a1,
  output logic             b1,
  output logic             c1,
  output logic             d1,
  output logic             a2,
  output logic             b2,
  output logic             c2,
  output logic             d2,
  input  logic             y1,
  input  logic             y2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [VEC_W-1:0] fail_vector,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = ($clog2(SETTLE_CYCLES) < 2) ? 2 : $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fvalid_q, fvalid_d;
  logic [VEC_W-1:0] fvec_q, fvec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic y1_s;
  logic y2_s;
  logic mismatch;

  two_4_input_and_tester_sync_2ff u_sync_y1 (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (y1),
    .q_o     (y1_s)
  );

  two_4_input_and_tester_sync_2ff u_sync_y2 (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (y2),
    .q_o     (y2_s)
  );

  // Either output wrong makes the vector fail; it is counted once.
  assign mismatch = ({y1_s, y2_s} != expected_y(vec_q));

  // State and datapath registers; reset discards any partial sweep.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      fvalid_q <= 1'b0;
      fvec_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      fvalid_q <= fvalid_d;
      fvec_q   <= fvec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  // Next state plus vector, settle counter and result capture.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    fvalid_d = fvalid_q;
    fvec_d   = fvec_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_SETTLE;
          vec_d    = '0;
          cnt_d    = '0;
          err_d    = '0;
          fvalid_d = 1'b0;
          fvec_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (!fvalid_q) begin
            fvalid_d = 1'b1;
            fvec_d   = vec_q;
          end
        end
        if (vec_q == LAST_VEC) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SETTLE;
          vec_d   = vec_q + 1'b1;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags are decoded from next-state values so they register together.
  always_comb begin
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_d == '0);
  end

  assign {a1, b1, c1, d1, a2, b2, c2, d2} = vec_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_q;
  assign fail_valid  = fvalid_q;
  assign fail_vector = fvec_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_two_4_input_and_tester.sv
// Bench for two_4_input_and_tester: a faultable AND gate model sits beside the
// tester; each sweep's results are compared with a sweep-level reference model.
module tb_two_4_input_and_tester;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       a1, b1, c1, d1, a2, b2, c2, d2;
  logic       y1, y2;
  logic       busy, done, pass, fail_valid;
  logic [8:0] err_count;
  logic [7:0] fail_vector;
  logic [1:0] dbg_state;

  two_4_input_and_tester #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .a1(a1), .b1(b1), .c1(c1), .d1(d1),
    .a2(a2), .b2(b2), .c2(c2), .d2(d2),
    .y1(y1), .y2(y2),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_valid(fail_valid),
    .fail_vector(fail_vector), .dbg_state(dbg_state)
  );

  // ---------------- gate under test with planted faults ----------------
  // mode 0 good, 1 y1 stuck-0, 2 y2 stuck-1, 3 outputs swapped, 4 random flips
  int           fault_mode = 0;
  logic [255:0] m1 = '0;
  logic [255:0] m2 = '0;
  logic [7:0]   vec_now;
  assign vec_now = {a1, b1, c1, d1, a2, b2, c2, d2};

  always_comb begin
    logic g1, g2;
    g1 = a1 & b1 & c1 & d1;
    g2 = a2 & b2 & c2 & d2;
    y1 = g1;
    y2 = g2;
    case (fault_mode)
      1: y1 = 1'b0;
      2: y2 = 1'b1;
      3: begin y1 = g2; y2 = g1; end
      4: begin y1 = g1 ^ m1[vec_now]; y2 = g2 ^ m2[vec_now]; end
      default: ;
    endcase
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Sweep-level reference: walk all 256 vectors arithmetically.
  function automatic void model_sweep(input int mode, output int err,
                                      output int fvalid, output int fvec);
    int i1, i2, o1, o2;
    err = 0; fvalid = 0; fvec = 0;
    for (int v = 0; v < 256; v++) begin
      i1 = ((v / 16) == 15) ? 1 : 0;
      i2 = ((v % 16) == 15) ? 1 : 0;
      o1 = i1; o2 = i2;
      case (mode)
        1: o1 = 0;
        2: o2 = 1;
        3: begin o1 = i2; o2 = i1; end
        4: begin o1 = i1 ^ int'(m1[v]); o2 = i2 ^ int'(m2[v]); end
        default: ;
      endcase
      if (o1 != i1 || o2 != i2) begin
        if (fvalid == 0) fvec = v;
        fvalid = 1;
        err++;
      end
    end
  endfunction

  // ---------------- scoreboard: vector sequence ----------------
  logic [7:0] exp_q[$];
  logic       busy_prev = 1'b0;
  logic [7:0] vec_prev = '0;
  bit         sb_skip = 1'b0;

  always @(negedge clk) begin
    if (reset_n && busy && (!busy_prev || vec_now != vec_prev)) begin
      if (!busy_prev) begin
        if (!sb_skip) check("sb_leftover", exp_q.size(), 0);
        sb_skip = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
      end
      if (exp_q.size() == 0) check("sb_extra_vec", vec_now, 256);
      else check("sb_vec", vec_now, exp_q.pop_front());
    end
    busy_prev = busy;
    vec_prev  = vec_now;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done) begin at = cyc; break; end
    end
    check("done_seen", (at >= 0) ? 1 : 0, 1);
  endtask

  task automatic run_sweep(input int mode, input bit pulses);
    int t0, at, e_err, e_fv, e_fvec;
    fault_mode = mode;
    model_sweep(mode, e_err, e_fv, e_fvec);
    repeat ($urandom_range(0, 5)) tick();
    start = 1'b1;
    t0 = cyc + 1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    at = -1;
    for (int i = 0; i < 1400; i++) begin
      tick();
      if (done) begin at = cyc; break; end
      start = (pulses && (cyc - t0) < 1200 && $urandom_range(0, 15) == 0);
    end
    start = 1'b0;
    check("done_seen", (at >= 0) ? 1 : 0, 1);
    check("done_latency", at - t0, 1280);
    check("err_count", err_count, e_err);
    check("fail_valid", fail_valid, e_fv);
    check("fail_vector", fail_vector, e_fvec);
    check("pass", pass, (e_err == 0) ? 1 : 0);
    check("busy_at_done", busy, 0);
    check("vec_holds_last", vec_now, 255);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int at, first;
    repeat (3) tick();
    check("rst_vec", vec_now, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_fvalid", fail_valid, 0);
    check("rst_fvec", fail_vector, 0);
    reset_n = 1'b1;
    repeat (2) tick();
    check("idle_no_start", busy, 0);

    // Good gate, fixed faults, then random flip patterns with noisy start.
    run_sweep(0, 1'b1);
    run_sweep(1, 1'b0);
    run_sweep(2, 1'b1);
    run_sweep(3, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int v = 0; v < 256; v++) begin
        m1[v] = ($urandom_range(0, 31) == 0);
        m2[v] = ($urandom_range(0, 31) == 0);
      end
      run_sweep(4, 1'b1);
    end

    // Reset in the middle of a failing sweep discards everything.
    fault_mode = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    at = -1;
    for (int i = 0; i < 1400; i++) begin
      tick();
      if (vec_now == 8'd100) begin at = cyc; break; end
    end
    check("reached_vec100", (at >= 0) ? 1 : 0, 1);
    check("err_before_reset_nonzero", (err_count != 0) ? 1 : 0, 1);
    reset_n = 1'b0;
    sb_skip = 1'b1;
    tick();
    reset_n = 1'b1;
    check("midrst_vec", vec_now, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", err_count, 0);
    check("midrst_fvalid", fail_valid, 0);
    check("midrst_done", done, 0);
    tick();
    run_sweep(0, 1'b0);

    // start held high: back-to-back sweeps, done exactly one cycle each.
    fault_mode = 0;
    start = 1'b1;
    first = cyc + 1;
    wait_done(1400, at);
    check("held_first_latency", at - first, 1280);
    first = at;
    tick();
    check("held_done_one_cycle", done, 0);
    check("held_busy_again", busy, 1);
    wait_done(1400, at);
    start = 1'b0;
    check("held_period", at - first, 1281);
    check("held_pass", pass, 1);
    tick();
    check("done_holds", done, 1);
    check("sb_leftover_end", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
